// File: rtl/dm_arbiter_pkg.sv
// Shared constants for the two-port data-memory arbiter.
package dm_arbiter_pkg;

    // Owner pointer encoding
    localparam logic [0:0] OWN0 = 1'b0;
    localparam logic [0:0] OWN1 = 1'b1;

    localparam int          MAX_BURST_DEF  = 4;
    // First out-of-range byte address: words 0..3072 are accessible
    localparam logic [31:0] ADDR_LIMIT_DEF = 32'h0000_3004;

    // Word-aligned and below the limit
    function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] limit);
        return (addr < limit) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Port-side and memory-side signals of the arbiter, bundled.
interface dm_arbiter_if;
    logic        req0, req1;
    logic        we0, we1;
    logic [31:0] addr0, addr1;
    logic [31:0] wd0, wd1;
    logic [31:0] pc0, pc1;
    logic        gnt0, gnt1;
    logic        rvalid0, rvalid1;
    logic [31:0] rdata;
    logic        err;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_pc;
    logic [31:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wd0, wd1, pc0, pc1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, err,
               mem_we, mem_addr, mem_wd, mem_pc
    );

    // Requesters plus memory
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wd0, wd1, pc0, pc1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, err,
               mem_we, mem_addr, mem_wd, mem_pc
    );
endinterface

// File: rtl/dm_rr_sel.sv
// Owner pointer and burst counter; decides which port is granted each cycle.
module dm_rr_sel
    import dm_arbiter_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [0:0] owner
);
    localparam int            CW      = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    logic [CW-1:0] cnt;
    logic [0:0]    own_q;
    logic          pick1;
    logic [0:0]    gnt_port;

    assign owner = own_q;

    // Under contention: stay with the owner until its burst is used up, then hand over
    assign pick1 = (own_q == OWN1) ^ (cnt >= CNT_MAX);

    // Grant decision, forced idle while reset is held
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            if (req0 && !req1)      gnt0 = 1'b1;
            else if (req1 && !req0) gnt1 = 1'b1;
            else if (req0 && req1) begin
                gnt1 = pick1;
                gnt0 = !pick1;
            end
        end
    end

    assign gnt_port = gnt1 ? OWN1 : OWN0;

    // Owner/burst tracking; an idle cycle clears the burst but keeps the owner
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            own_q <= OWN0;
            cnt   <= '0;
        end else if (gnt0 || gnt1) begin
            own_q <= gnt_port;
            if (gnt_port != own_q)  cnt <= CW'(1);
            else if (cnt < CNT_MAX) cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: request mux, range check, 1-cycle read return.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int          MAX_BURST  = MAX_BURST_DEF,
    parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    dm_arbiter_if.slave  bus
);
    logic        gnt0, gnt1, granted;
    logic [0:0]  owner, sel;
    logic        sel_we, bad;
    logic [31:0] sel_addr, sel_wd, sel_pc;
    logic        rvalid0_q, rvalid1_q, err_q;
    logic [31:0] rdata_q;

    dm_rr_sel #(.MAX_BURST(MAX_BURST)) u_rr_sel (
        .clk   (clk),
        .reset (reset),
        .req0  (bus.req0),
        .req1  (bus.req1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .owner (owner)
    );

    assign granted = gnt0 || gnt1;

    // With no grant the mux parks on the owner's inputs
    always_comb begin
        sel = owner;
        if (gnt1)      sel = OWN1;
        else if (gnt0) sel = OWN0;
    end

    // Request mux of the selected port
    always_comb begin
        sel_we   = bus.we0;
        sel_addr = bus.addr0;
        sel_wd   = bus.wd0;
        sel_pc   = bus.pc0;
        if (sel == OWN1) begin
            sel_we   = bus.we1;
            sel_addr = bus.addr1;
            sel_wd   = bus.wd1;
            sel_pc   = bus.pc1;
        end
    end

    assign bad = !addr_ok(sel_addr, ADDR_LIMIT);

    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.mem_we   = granted && sel_we && !bad;
    assign bus.mem_addr = sel_addr;
    assign bus.mem_wd   = sel_wd;
    assign bus.mem_pc   = sel_pc;

    // Read return and error pulse; rejected reads still complete, with zero data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            rvalid0_q <= gnt0 && !sel_we;
            rvalid1_q <= gnt1 && !sel_we;
            err_q     <= granted && bad;
            if (granted && !sel_we)
                rdata_q <= bad ? '0 : bus.mem_rdata;
        end
    end

    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata   = rdata_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_dm_arbiter;
    localparam int          MAXB  = 4;
    localparam logic [31:0] LIMIT = 32'h0000_3004;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    dm_arbiter_if bif ();

    dm_arbiter #(.MAX_BURST(MAXB), .ADDR_LIMIT(LIMIT)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: last granted port, length of its current streak, pending registered outputs
    int          m_own    = 0;
    int          m_streak = 0;
    logic        e_rv0 = 1'b0, e_rv1 = 1'b0, e_err = 1'b0;
    logic [31:0] e_rd  = '0;

    always @(negedge clk) begin : cmp
        int          g;
        int          s;
        logic        w, bd;
        logic [31:0] a, d, p;
        if (!reset) begin
            m_own = 0; m_streak = 0;
            e_rv0 = 1'b0; e_rv1 = 1'b0; e_err = 1'b0; e_rd = '0;
        end
        chk("cmp_rvalid0", bif.rvalid0, e_rv0);
        chk("cmp_rvalid1", bif.rvalid1, e_rv1);
        chk("cmp_err", bif.err, e_err);
        if (e_rv0 || e_rv1 || !reset) chk("cmp_rdata", bif.rdata, e_rd);

        g = -1;
        if (reset) begin
            if (bif.req0 && !bif.req1)      g = 0;
            else if (bif.req1 && !bif.req0) g = 1;
            else if (bif.req0 && bif.req1)  g = (m_streak >= MAXB) ? 1 - m_own : m_own;
        end
        s  = (g < 0) ? m_own : g;
        w  = s ? bif.we1   : bif.we0;
        a  = s ? bif.addr1 : bif.addr0;
        d  = s ? bif.wd1   : bif.wd0;
        p  = s ? bif.pc1   : bif.pc0;
        bd = (a >= LIMIT) || (a % 4 != 0);

        chk("cmp_gnt0", bif.gnt0, g == 0);
        chk("cmp_gnt1", bif.gnt1, g == 1);
        chk("cmp_mem_we", bif.mem_we, (g >= 0) && w && !bd);
        chk("cmp_mem_addr", bif.mem_addr, a);
        chk("cmp_mem_wd", bif.mem_wd, d);
        chk("cmp_mem_pc", bif.mem_pc, p);

        if (reset) begin
            e_rv0 = (g == 0) && !w;
            e_rv1 = (g == 1) && !w;
            e_err = (g >= 0) && bd;
            if (g >= 0 && !w) e_rd = bd ? 32'h0 : bif.mem_rdata;
            if (g >= 0) begin
                m_streak = (g == m_own) ? ((m_streak + 1 > MAXB) ? MAXB : m_streak + 1) : 1;
                m_own    = g;
            end else begin
                m_streak = 0;
            end
        end
    end

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_3000;
            1:       return 32'h0000_3004;
            2:       return ($urandom_range(0, 3071) << 2) | $urandom_range(1, 3);
            3:       return 32'h0000_3004 + ($urandom_range(0, 1000) << 2);
            default: return $urandom_range(0, 3072) << 2;
        endcase
    endfunction

    initial begin
        int pat [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

        reset = 1'b0;
        bif.req0 = 1'b1; bif.req1 = 1'b0; bif.we0 = 1'b0; bif.we1 = 1'b0;
        bif.addr0 = 32'h0; bif.addr1 = 32'h0; bif.wd0 = 32'h0; bif.wd1 = 32'h0;
        bif.pc0 = 32'h0; bif.pc1 = 32'h0; bif.mem_rdata = 32'h0;
        tick(); tick();
        chk("rst_gnt0", bif.gnt0, 1'b0);
        chk("rst_mem_we", bif.mem_we, 1'b0);
        chk("rst_rvalid0", bif.rvalid0, 1'b0);
        chk("rst_rvalid1", bif.rvalid1, 1'b0);
        chk("rst_rdata", bif.rdata, 32'h0);
        chk("rst_err", bif.err, 1'b0);

        // Port-0 read
        reset = 1'b1;
        bif.addr0 = 32'h10; bif.mem_rdata = 32'hDEAD_BEEF; #1;
        chk("rd0_gnt0", bif.gnt0, 1'b1);
        chk("rd0_gnt1", bif.gnt1, 1'b0);
        tick();

        // Port-1 write
        bif.req0 = 1'b0;
        bif.req1 = 1'b1; bif.we1 = 1'b1; bif.addr1 = 32'h20; bif.wd1 = 32'h55; bif.pc1 = 32'h3000;
        bif.mem_rdata = 32'h1234_5678; #1;
        chk("rd0_rvalid0", bif.rvalid0, 1'b1);
        chk("rd0_rdata", bif.rdata, 32'hDEAD_BEEF);
        chk("wr1_gnt1", bif.gnt1, 1'b1);
        chk("wr1_mem_we", bif.mem_we, 1'b1);
        chk("wr1_mem_addr", bif.mem_addr, 32'h20);
        chk("wr1_mem_wd", bif.mem_wd, 32'h55);
        chk("wr1_mem_pc", bif.mem_pc, 32'h3000);
        tick();

        bif.req1 = 1'b0; bif.we1 = 1'b0;
        bif.req0 = 1'b1; bif.addr0 = 32'h100; #1;
        chk("wr1_no_rvalid1", bif.rvalid1, 1'b0);
        chk("wr1_no_err", bif.err, 1'b0);
        tick();
        bif.req0 = 1'b0; #1;
        chk("idle_gnt0", bif.gnt0, 1'b0);
        chk("idle_mem_we", bif.mem_we, 1'b0);
        tick();

        // Contention
        bif.req0 = 1'b1; bif.req1 = 1'b1; bif.addr1 = 32'h104;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("cont_gnt1_%0d", i), bif.gnt1, pat[i]);
            chk($sformatf("cont_gnt0_%0d", i), bif.gnt0, !pat[i]);
            tick();
        end
        bif.req1 = 1'b0;

        // Rejected write then rejected read
        bif.we0 = 1'b1; bif.addr0 = 32'h3004; bif.wd0 = 32'h77; #1;
        chk("badwr_gnt0", bif.gnt0, 1'b1);
        chk("badwr_mem_we", bif.mem_we, 1'b0);
        tick();
        bif.we0 = 1'b0; bif.addr0 = 32'h6; bif.mem_rdata = 32'hFFFF_FFFF; #1;
        chk("badwr_err", bif.err, 1'b1);
        chk("badwr_no_rvalid", bif.rvalid0, 1'b0);
        tick();
        bif.req0 = 1'b0; #1;
        chk("badrd_rvalid0", bif.rvalid0, 1'b1);
        chk("badrd_rdata", bif.rdata, 32'h0);
        chk("badrd_err", bif.err, 1'b1);
        tick();
        chk("err_one_cycle", bif.err, 1'b0);

        // Reset during a port-1 write
        bif.req1 = 1'b1; bif.we1 = 1'b1; bif.addr1 = 32'h40; bif.wd1 = 32'hAA; #1;
        chk("mid_mem_we_pre", bif.mem_we, 1'b1);
        reset = 1'b0; #1;
        chk("mid_mem_we", bif.mem_we, 1'b0);
        chk("mid_gnt1", bif.gnt1, 1'b0);
        tick();
        reset = 1'b1;
        bif.req0 = 1'b1; bif.we1 = 1'b0; #1;
        chk("post_rst_gnt0", bif.gnt0, 1'b1);
        chk("post_rst_gnt1", bif.gnt1, 1'b0);
        tick();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 99) != 0);
            bif.req0      = ($urandom_range(0, 3) != 0);
            bif.req1      = ($urandom_range(0, 3) != 0);
            bif.we0       = $urandom_range(0, 1);
            bif.we1       = $urandom_range(0, 1);
            bif.addr0     = rand_addr();
            bif.addr1     = rand_addr();
            bif.wd0       = $urandom;
            bif.wd1       = $urandom;
            bif.pc0       = $urandom;
            bif.pc1       = $urandom;
            bif.mem_rdata = $urandom;
            tick();
        end

        reset = 1'b1; bif.req0 = 1'b0; bif.req1 = 1'b0;
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
